// File: rtl/pipeline_fifo.sv
// Elastic FIFO between two pipeline stages using a valid/allow handshake on both sides.
// Head-of-queue data falls through combinationally. allow_in depends only on internal
// state and flush, so there is no combinational path from allow_out to allow_in.
//
// Ports:
//   clk        clock, all state updates on posedge
//   resetn     asynchronous active-low reset
//   flush      discard all entries and any incoming item this cycle
//   valid_in   upstream item present on in
//   allow_in   FIFO can accept an item this cycle
//   in         upstream payload
//   valid_out  item present on out
//   allow_out  downstream accepts the item this cycle
//   out        head-of-queue payload
//   count      number of valid entries
module pipeline_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       valid_in,
    output logic                       allow_in,
    input  logic [WIDTH-1:0]           in,
    output logic                       valid_out,
    input  logic                       allow_out,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [AW:0] PtrOne = 1;
    localparam logic [CW-1:0] CntOne = 1;

    logic [WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic empty;
    logic full;
    logic push;
    logic pop;

    assign empty = (rd_ptr_q == wr_ptr_q);
    assign full  = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);

    // A pop in the same cycle does not open a slot for a push when full.
    assign allow_in  = resetn & (flush | ~full);
    assign valid_out = ~empty;
    assign out       = mem[rd_ptr_q[AW-1:0]];
    assign count     = count_q;

    assign push = valid_in & allow_in & ~flush;
    assign pop  = valid_out & allow_out & ~flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            if (push && !pop) begin
                count_d = count_q + CntOne;
            end else if (pop && !push) begin
                count_d = count_q - CntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= in;
        end
    end

endmodule

// File: tb/tb_pipeline_fifo.sv
// Directed self-checking bench for pipeline_fifo (WIDTH=32, DEPTH=4).
module tb_pipeline_fifo;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        valid_in;
    logic        allow_in;
    logic [31:0] in;
    logic        valid_out;
    logic        allow_out;
    logic [31:0] out;
    logic [2:0]  count;

    int vectors = 0;
    int errors  = 0;

    pipeline_fifo #(
        .WIDTH(32),
        .DEPTH(4)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (flush),
        .valid_in (valid_in),
        .allow_in (allow_in),
        .in       (in),
        .valid_out(valid_out),
        .allow_out(allow_out),
        .out      (out),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sampling happens 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push1(input logic [31:0] d);
        valid_in = 1'b1;
        in       = d;
        tick();
        valid_in = 1'b0;
    endtask

    initial begin
        resetn    = 1'b0;
        flush     = 1'b0;
        valid_in  = 1'b0;
        allow_out = 1'b0;
        in        = '0;

        // Reset state
        #3;
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_allow_in", 32'(allow_in), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        #1;
        chk("rel_allow_in", 32'(allow_in), 32'd1);
        chk("rel_valid_out", 32'(valid_out), 32'd0);

        // 1: single push, one-cycle latency
        push1(32'h11);
        chk("t1_valid_out", 32'(valid_out), 32'd1);
        chk("t1_out", out, 32'h11);
        chk("t1_count", 32'(count), 32'd1);
        allow_out = 1'b1;
        tick();
        allow_out = 1'b0;
        chk("t1_drained", 32'(valid_out), 32'd0);
        chk("t1_count0", 32'(count), 32'd0);

        // 2: fill to DEPTH, reject overflow, drain in order
        for (int i = 1; i <= 4; i++) push1(32'(i));
        chk("t2_count_full", 32'(count), 32'd4);
        chk("t2_allow_in_full", 32'(allow_in), 32'd0);
        push1(32'h5);
        chk("t2_overflow_count", 32'(count), 32'd4);
        chk("t2_overflow_head", out, 32'h1);
        allow_out = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t2_drain_valid", 32'(valid_out), 32'd1);
            chk("t2_drain_out", out, 32'(i));
            tick();
        end
        allow_out = 1'b0;
        chk("t2_empty", 32'(valid_out), 32'd0);
        chk("t2_count0", 32'(count), 32'd0);

        // 3: full with pop and offered push -> only the pop happens
        for (int i = 6; i <= 9; i++) push1(32'(i));
        valid_in  = 1'b1;
        in        = 32'hA;
        allow_out = 1'b1;
        chk("t3_allow_in_full", 32'(allow_in), 32'd0);
        tick();
        chk("t3_count_pop_only", 32'(count), 32'd3);
        chk("t3_head", out, 32'h7);
        chk("t3_allow_in_rise", 32'(allow_in), 32'd1);
        allow_out = 1'b0;
        tick();
        valid_in = 1'b0;
        chk("t3_count_refill", 32'(count), 32'd4);
        allow_out = 1'b1;
        for (int i = 7; i <= 10; i++) begin
            chk("t3_drain_out", out, 32'(i));
            tick();
        end
        allow_out = 1'b0;
        chk("t3_empty", 32'(valid_out), 32'd0);

        // 4: steady stream, pointers wrap several times
        push1(32'h100);
        valid_in  = 1'b1;
        allow_out = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            in = 32'h100 + 32'(n);
            chk("t4_stream_out", out, 32'h100 + 32'(n - 1));
            chk("t4_stream_count", 32'(count), 32'd1);
            tick();
        end
        valid_in = 1'b0;
        chk("t4_last_out", out, 32'h114);
        tick();
        allow_out = 1'b0;
        chk("t4_count0", 32'(count), 32'd0);

        // 5: flush with an incoming item
        push1(32'h21);
        push1(32'h22);
        push1(32'h23);
        chk("t5_count3", 32'(count), 32'd3);
        flush     = 1'b1;
        valid_in  = 1'b1;
        in        = 32'h24;
        allow_out = 1'b1;
        #1;
        chk("t5_allow_in_flush", 32'(allow_in), 32'd1);
        tick();
        flush     = 1'b0;
        valid_in  = 1'b0;
        allow_out = 1'b0;
        chk("t5_count_flushed", 32'(count), 32'd0);
        chk("t5_valid_flushed", 32'(valid_out), 32'd0);
        push1(32'h31);
        chk("t5_post_flush_out", out, 32'h31);
        chk("t5_post_flush_count", 32'(count), 32'd1);
        allow_out = 1'b1;
        tick();
        allow_out = 1'b0;
        chk("t5_empty", 32'(valid_out), 32'd0);

        // 6: asynchronous reset mid-stream
        push1(32'h41);
        push1(32'h42);
        chk("t6_count2", 32'(count), 32'd2);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_rst_valid_out", 32'(valid_out), 32'd0);
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_allow_in", 32'(allow_in), 32'd0);
        #1;
        resetn = 1'b1;
        tick();
        push1(32'hAB);
        chk("t6_first_out", out, 32'hAB);
        chk("t6_first_count", 32'(count), 32'd1);
        chk("t6_first_valid", 32'(valid_out), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
